column_output_collector: RTL

COLUMN_OUTPUT_COLLECTOR -- requirements
Module: column_output_collector

---
 rtl/column_output_collector.sv | 138 +++++++++++++
 1 files changed

// File: rtl/column_output_collector.sv
// Column output collector: delays launch pulses to the capture point, then
// post-processes the column total (ReLU, round, shift, saturate) into a FIFO.
//
// Ports:
//   clk, reset      - single clock, synchronous active-high reset
//   launch          - pulse when the last operand group enters the column
//   total_output    - 28-bit signed column accumulator result
//   relu_en, shift  - post-processing controls, sampled at capture
//   out_valid/out_ready/out_data - FIFO head handshake (16-bit signed)
//   fifo_count      - occupied FIFO entries
//   overflow        - sticky: a result was dropped on a full FIFO
module column_output_collector #(
    parameter int LATENCY = 19,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     launch,
    input  logic [27:0]              total_output,
    input  logic                     relu_en,
    input  logic [4:0]               shift,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [LATENCY-1:0] launch_sr_q, launch_sr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [15:0]        mem_q [DEPTH];
    logic [15:0]        mem_d [DEPTH];

    logic               capture;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    logic [4:0]         shamt;
    logic signed [28:0] relu_val;
    logic signed [28:0] rnd_bias;
    logic signed [28:0] rounded;
    logic signed [28:0] shifted;
    logic [15:0]        result;

    // Launch delay line; the last tap marks the capture cycle.
    always_comb begin
        launch_sr_d = (launch_sr_q << 1) | LATENCY'(launch);
    end

    assign capture = launch_sr_q[LATENCY-1];

    // Post-processing datapath. 29 bits so the rounding bias cannot
    // overflow even for the largest positive 28-bit input.
    always_comb begin
        shamt    = (shift > 5'd27) ? 5'd27 : shift;
        relu_val = {total_output[27], total_output};
        if (relu_en && total_output[27]) begin
            relu_val = '0;
        end
        rnd_bias = '0;
        if (shamt != 5'd0) begin
            rnd_bias = 29'sd1 <<< (shamt - 5'd1);
        end
        rounded = relu_val + rnd_bias;
        shifted = rounded >>> shamt;
        if (shifted > 29'sd32767) begin
            result = 16'h7FFF;
        end else if (shifted < -29'sd32768) begin
            result = 16'h8000;
        end else begin
            result = shifted[15:0];
        end
    end

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign pop   = !empty && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push  = capture && (!full || pop);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            mem_d[wr_ptr_q] = result;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (capture && full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            launch_sr_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            launch_sr_q <= launch_sr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage needs no reset: it is only read while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign out_valid  = !empty;
    assign out_data   = empty ? 16'h0000 : mem_q[rd_ptr_q];
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule
